vga_rx_timing: RTL and testbench

Receive-side VGA timing recovery block. It is the counterpart of the pixel-timing generator: it consumes HS/VS/RGB as driven onto the VGA pins, measures line and frame periods, and locks to the configured mode. Once locked it re-derives the pixel coordinates (x, y), the active-video flag and the pixel colour. It sits in loopback and self-test paths, fed from the same board clock and pixel strobe as the generator.

---
 rtl/vga_rx_pkg.sv | 31 +++
 rtl/vga_sync_edge.sv | 23 ++
 rtl/vga_rx_timing.sv | 197 +++++++++++++++++++
 tb/tb_vga_rx_timing.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// Shared types and default 640x480 timing for the VGA receive-side timing recovery.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // 640x480 @ 60 Hz default mode, in pixels / lines.
  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_H_FP        = 16;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BP        = 48;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_V_FP        = 10;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BP        = 33;
  localparam int VGA_LOCK_FRAMES = 2;

  // Period of a line or frame: all four segments together.
  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First active position, counted from the sync assertion edge.
  function automatic int vga_start(input int sync, input int bp);
    return sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Strobe-qualified sampler with falling-edge (sync assertion) detect.
module vga_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_stb,
  input  logic i_sig,
  output logic o_fall
);

  logic prev_q;

  // Hold the previous strobe-time sample; resets deasserted so no false edge follows reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= 1'b1;
    end else if (i_stb) begin
      prev_q <= i_sig;
    end
  end

  assign o_fall = i_stb & prev_q & ~i_sig;

endmodule

// File: rtl/vga_rx_timing.sv
// Recovers line/frame timing from VGA pins, locks to the configured mode,
// and re-derives pixel coordinates, active-video and colour.
// Handshake: o_valid is a one-cycle pulse one i_clk after each i_pix_stb;
// there is no backpressure, the consumer must take every o_valid beat.
module vga_rx_timing
  import vga_rx_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_r,
  input  logic        i_g,
  input  logic        i_b,
  output logic        o_valid,
  output logic        o_de,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic [2:0]  o_rgb,
  output logic        o_locked,
  output logic [10:0] o_h_total,
  output logic [9:0]  o_v_total,
  output logic        o_frame_start,
  output logic        o_err,
  output state_t      o_state
);

  localparam logic [10:0] H_TOTAL = 11'(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam logic [10:0] H_START = 11'(vga_start(H_SYNC, H_BP));
  localparam logic [10:0] H_END   = 11'(vga_start(H_SYNC, H_BP) + H_ACTIVE);
  localparam logic [9:0]  V_TOTAL = 10'(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam logic [9:0]  V_START = 10'(vga_start(V_SYNC, V_BP));
  localparam logic [9:0]  V_END   = 10'(vga_start(V_SYNC, V_BP) + V_ACTIVE);
  localparam logic [10:0] H_MAX   = 11'd2047;
  localparam logic [9:0]  V_MAX   = 10'd1023;
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

  logic        hs_edge, vs_edge;
  state_t      state_q, state_d;
  logic [2:0]  match_q, match_d;
  logic [10:0] h_cnt, h_nxt, h_len, htot_d;
  logic [9:0]  v_cnt, v_nxt, v_inc, vtot_d;
  logic        line_bad_q, line_bad_d;
  logic        h_sat, len_bad, frame_ok, err_d, de_d;
  logic [9:0]  x_d;
  logic [8:0]  y_d;

  vga_sync_edge u_hs_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_stb   (i_pix_stb),
    .i_sig   (i_hs),
    .o_fall  (hs_edge)
  );

  vga_sync_edge u_vs_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_stb   (i_pix_stb),
    .i_sig   (i_vs),
    .o_fall  (vs_edge)
  );

  assign len_bad  = hs_edge && (h_len != H_TOTAL);
  // The line closed by a coincident HS edge still belongs to the frame being judged.
  assign frame_ok = !line_bad_q && !len_bad && (vtot_d == V_TOTAL);

  // Line/frame counters and period measurements for the current strobe.
  always_comb begin
    h_len      = (h_cnt == H_MAX) ? H_MAX : h_cnt + 11'd1;
    v_inc      = (v_cnt == V_MAX) ? V_MAX : v_cnt + 10'd1;
    h_nxt      = h_cnt;
    v_nxt      = v_cnt;
    htot_d     = o_h_total;
    vtot_d     = o_v_total;
    line_bad_d = line_bad_q;
    h_sat      = 1'b0;
    if (i_pix_stb) begin
      if (hs_edge) begin
        h_nxt  = 11'd0;
        htot_d = h_len;
      end else begin
        h_nxt = h_len;
        h_sat = (h_cnt == H_MAX - 11'd1);
      end
      if (vs_edge) begin
        vtot_d     = hs_edge ? v_inc : v_cnt;
        v_nxt      = 10'd0;
        line_bad_d = 1'b0;
      end else begin
        if (hs_edge) v_nxt = v_inc;
        if (len_bad) line_bad_d = 1'b1;
      end
    end
  end

  // Lock state machine: next state, match count and error pulse.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    err_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          state_d = ACQUIRE;
          match_d = 3'd0;
        end
      end
      ACQUIRE: begin
        if (h_sat) begin
          state_d = SEARCH;
          match_d = 3'd0;
        end else if (vs_edge) begin
          if (frame_ok) begin
            match_d = match_q + 3'd1;
            if (match_q + 3'd1 == LOCK_N) state_d = LOCKED;
          end else begin
            match_d = 3'd0;
          end
        end
      end
      LOCKED: begin
        if (len_bad || (vs_edge && (vtot_d != V_TOTAL)) || h_sat) begin
          err_d   = 1'b1;
          state_d = SEARCH;
          match_d = 3'd0;
        end
      end
      default: begin
        state_d = SEARCH;
        match_d = 3'd0;
      end
    endcase
  end

  // Active-video window and coordinates from the post-update counters.
  always_comb begin
    de_d = (state_d == LOCKED) &&
           (h_nxt >= H_START) && (h_nxt < H_END) &&
           (v_nxt >= V_START) && (v_nxt < V_END);
    x_d  = de_d ? 10'(h_nxt - H_START) : 10'd0;
    y_d  = de_d ? 9'(v_nxt - V_START) : 9'd0;
  end

  // State, counters and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= SEARCH;
      match_q       <= 3'd0;
      h_cnt         <= 11'd0;
      v_cnt         <= 10'd0;
      line_bad_q    <= 1'b0;
      o_valid       <= 1'b0;
      o_de          <= 1'b0;
      o_x           <= 10'd0;
      o_y           <= 9'd0;
      o_rgb         <= 3'd0;
      o_locked      <= 1'b0;
      o_h_total     <= 11'd0;
      o_v_total     <= 10'd0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      state_q       <= state_d;
      match_q       <= match_d;
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      line_bad_q    <= line_bad_d;
      o_valid       <= i_pix_stb;
      o_frame_start <= vs_edge;
      o_err         <= err_d;
      o_locked      <= (state_d == LOCKED);
      o_h_total     <= htot_d;
      o_v_total     <= vtot_d;
      if (i_pix_stb) begin
        o_de  <= de_d;
        o_x   <= x_d;
        o_y   <= y_d;
        o_rgb <= de_d ? {i_r, i_g, i_b} : 3'd0;
      end
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_vga_rx_timing.sv
// Bench for vga_rx_timing: reference pin generator, spec-level lock model, scoreboard.
module tb_vga_rx_timing;
  import vga_rx_pkg::*;

  // Compact timing mode so a frame is a few hundred strobes.
  localparam int HA = 16, HFP = 2, HSY = 4, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 2;
  localparam int LOCK = 2;
  localparam int HT = HA + HFP + HSY + HBP;   // 25
  localparam int VT = VA + VFP + VSY + VBP;   // 13
  localparam int HST = HSY + HBP;             // 7
  localparam int VST = VSY + VBP;             // 4
  localparam int W = 47;

  logic clk = 1'b0;
  logic i_rst_n = 1'b1, i_pix_stb = 1'b0, i_hs = 1'b1, i_vs = 1'b1;
  logic i_r = 1'b0, i_g = 1'b0, i_b = 1'b0;
  logic o_valid, o_de, o_locked, o_frame_start, o_err;
  logic [9:0] o_x;
  logic [8:0] o_y;
  logic [2:0] o_rgb;
  logic [10:0] o_h_total;
  logic [9:0] o_v_total;
  state_t o_state;

  vga_rx_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .LOCK_FRAMES(LOCK)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_pix_stb(i_pix_stb),
    .i_hs(i_hs), .i_vs(i_vs), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_valid(o_valid), .o_de(o_de), .o_x(o_x), .o_y(o_y), .o_rgb(o_rgb),
    .o_locked(o_locked), .o_h_total(o_h_total), .o_v_total(o_v_total),
    .o_frame_start(o_frame_start), .o_err(o_err), .o_state(o_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_vec;
  assign obs_vec = {o_de, o_x, o_y, o_rgb, o_frame_start, o_err, o_locked, o_h_total, o_v_total};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: pin history, line/frame measurement, lock rule.
  logic m_prev_hs, m_prev_vs, m_locked, m_seen, m_frame_bad;
  int   m_pos, m_lines, m_ht, m_vt, m_good;

  task automatic model_reset();
    m_prev_hs = 1'b1; m_prev_vs = 1'b1;
    m_locked = 1'b0; m_seen = 1'b0; m_frame_bad = 1'b0;
    m_pos = 0; m_lines = 0; m_ht = 0; m_vt = 0; m_good = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    i_rst_n = 1'b0;
    i_pix_stb = 1'b0;
    #1;
    check_eq("rst_outs_now", 64'({o_valid, obs_vec}), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("rst_outs_hold", 64'({o_valid, obs_vec}), 64'd0);
    check_eq("rst_state", 64'(o_state), 64'(SEARCH));
    i_rst_n = 1'b1;
    model_reset();
  endtask

  // Driver: one strobe every 4 clocks; gx/gy < 0 marks positions outside the raster.
  task automatic drive_pix(input logic hs, input logic vs, input logic [2:0] rgb,
                           input int gx, input int gy);
    logic hs_fall, vs_fall, sat, err, clean, de;
    int len;
    int x, y;
    @(negedge clk);
    i_pix_stb = 1'b1; i_hs = hs; i_vs = vs; {i_r, i_g, i_b} = rgb;
    hs_fall = m_prev_hs && !hs;
    vs_fall = m_prev_vs && !vs;
    m_prev_hs = hs; m_prev_vs = vs;
    len = (m_pos + 1 > 2047) ? 2047 : m_pos + 1;
    sat = 1'b0; err = 1'b0; clean = 1'b0;
    if (hs_fall) begin
      m_pos = 0;
      m_ht = len;
      if (len != HT) m_frame_bad = 1'b1;
    end else if (m_pos < 2047) begin
      m_pos++;
      sat = (m_pos == 2047);
    end
    if (vs_fall) begin
      m_vt = m_lines + (hs_fall ? 1 : 0);
      if (m_vt > 1023) m_vt = 1023;
      m_lines = 0;
      clean = !m_frame_bad;
      m_frame_bad = 1'b0;
    end else if (hs_fall && m_lines < 1023) begin
      m_lines++;
    end
    if (m_locked) begin
      if ((hs_fall && len != HT) || (vs_fall && m_vt != VT) || sat) begin
        err = 1'b1; m_locked = 1'b0; m_seen = 1'b0;
      end
    end else if (m_seen) begin
      if (sat) m_seen = 1'b0;
      else if (vs_fall) begin
        if (clean && m_vt == VT) m_good++; else m_good = 0;
        if (m_good == LOCK) m_locked = 1'b1;
      end
    end else if (vs_fall) begin
      m_seen = 1'b1; m_good = 0;
    end
    de = m_locked && gx >= HST && gx < HST + HA && gy >= VST && gy < VST + VA;
    x = de ? gx - HST : 0;
    y = de ? gy - VST : 0;
    exp_q.push_back({de, 10'(x), 9'(y), de ? rgb : 3'b000, vs_fall, err, m_locked,
                     11'(m_ht), 10'(m_vt)});
    @(negedge clk);
    i_pix_stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input int short_line, input int rst_line, input bit origin_mode);
    logic [2:0] rgb;
    for (int gy = 0; gy < VT; gy++) begin
      for (int gx = 0; gx < ((gy == short_line) ? HT - 1 : HT); gx++) begin
        if (gy == rst_line && gx == HT / 2) apply_reset();
        if (origin_mode) rgb = (gx == HST && gy == VST) ? 3'b111 : 3'b000;
        else rgb = 3'($urandom_range(0, 7));
        drive_pix(gx >= HSY, gy >= VSY, rgb, gx, gy);
      end
    end
  endtask

  task automatic send_fill(input int n, input logic hs);
    for (int i = 0; i < n; i++) drive_pix(hs, 1'b1, 3'($urandom_range(0, 7)), -1, -1);
  endtask

  // Scoreboard / monitor: sampled on the falling edge after each strobe.
  int n_de = 0, n_origin = 0, n_de_unlocked = 0, n_err = 0, n_fs = 0;
  int lock_fs = 0;
  logic lock_with_fs = 1'b0, mon_prev_locked = 1'b0;
  logic [10:0] err_htot = '0, fs_htot = '0;

  always @(negedge clk) begin : mon
    logic [W-1:0] exp_v;
    if (!i_rst_n) begin
      mon_prev_locked <= 1'b0;
    end else if (o_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("valid_extra", 64'(o_valid), 64'd0);
      end else begin
        exp_v = exp_q.pop_front();
        check_eq("pix", 64'(obs_vec), 64'(exp_v));
      end
      if (o_de) n_de <= n_de + 1;
      if (o_de && o_x == 10'd0 && o_y == 9'd0 && o_rgb == 3'b111) n_origin <= n_origin + 1;
      if (o_de && !o_locked) n_de_unlocked <= n_de_unlocked + 1;
      if (o_err) begin
        n_err <= n_err + 1;
        err_htot <= o_h_total;
      end
      if (o_frame_start) begin
        n_fs <= n_fs + 1;
        fs_htot <= o_h_total;
      end
      if (o_locked && !mon_prev_locked) begin
        lock_fs <= n_fs + (o_frame_start ? 1 : 0);
        lock_with_fs <= o_frame_start;
      end
      mon_prev_locked <= o_locked;
    end
  end

  initial begin : scenario
    int base_de, base_org, base_err, base_fs, base_unl, sl;
    model_reset();
    apply_reset();

    // Clean stream: lock on the 3rd VS edge, coincident HS/VS gives a full frame count.
    base_fs = n_fs;
    for (int f = 0; f < 3; f++) send_frame(-1, -1, 1'b0);
    check_eq("lock_clean", 64'(o_locked), 64'd1);
    check_eq("lock_vs_edge", 64'(lock_fs - base_fs), 64'd3);
    check_eq("lock_with_fs", 64'(lock_with_fs), 64'd1);
    check_eq("h_total", 64'(o_h_total), 64'(HT));
    check_eq("v_total", 64'(o_v_total), 64'(VT));

    // Pixel recovery: single white pixel at the origin.
    base_de = n_de; base_org = n_origin;
    send_frame(-1, -1, 1'b1);
    check_eq("de_per_frame", 64'(n_de - base_de), 64'(HA * VA));
    check_eq("origin_once", 64'(n_origin - base_org), 64'd1);

    // Short line while locked, then relock.
    base_err = n_err;
    send_frame(5, -1, 1'b0);
    check_eq("short_err", 64'(n_err - base_err), 64'd1);
    check_eq("short_htot", 64'(err_htot), 64'(HT - 1));
    check_eq("short_unlock", 64'(o_locked), 64'd0);
    for (int f = 0; f < 3; f++) send_frame(-1, -1, 1'b0);
    check_eq("short_relock", 64'(o_locked), 64'd1);

    // HS stuck low past saturation.
    base_err = n_err;
    send_fill(2100, 1'b0);
    send_fill(10, 1'b1);
    check_eq("stuck_err", 64'(n_err - base_err), 64'd1);
    check_eq("stuck_unlock", 64'(o_locked), 64'd0);
    send_frame(-1, -1, 1'b0);
    check_eq("stuck_sat_len", 64'(fs_htot), 64'd2047);
    for (int f = 0; f < 2; f++) send_frame(-1, -1, 1'b0);
    check_eq("stuck_relock", 64'(o_locked), 64'd1);

    // Reset mid-frame inside the active area.
    base_unl = n_de_unlocked;
    send_frame(-1, VST + VA / 2, 1'b0);
    check_eq("rst_mid_unlock", 64'(o_locked), 64'd0);
    for (int f = 0; f < 3; f++) send_frame(-1, -1, 1'b0);
    check_eq("rst_no_de", 64'(n_de_unlocked - base_unl), 64'd0);
    check_eq("rst_relock", 64'(o_locked), 64'd1);

    // Random frames with occasional short lines.
    for (int f = 0; f < 5; f++) begin
      sl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, VT - 1)) : -1;
      send_frame(sl, -1, 1'b0);
    end

    repeat (4) @(negedge clk);
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
